// File: rtl/mdu_hilo.sv
// mdu_hilo: E-stage multiply/divide unit that owns the HI/LO registers and serves mf/mt hi/lo.
// Latency: mult/multu take MULT_CYCLES and div/divu take DIV_CYCLES; mthi/mtlo write at the next edge; mfhi/mflo are combinational.
// Backpressure: busy is registered and high while an op is in flight; inputs arriving then are ignored. Optional MDU_CANCEL_EN adds a cancel input.
module mdu_hilo #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        start,
  input  logic [3:0]  HILO_Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HILO_Out,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic        busy_nxt;
  logic [31:0] res_hi, res_lo, res_hi_nxt, res_lo_nxt;
  logic        res_wr, res_wr_nxt;
  logic [31:0] hi_nxt, lo_nxt;
  logic        kill;

  // Flush request; tied off when the cancel feature is not built.
`ifdef MDU_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  logic [63:0] prod_s, prod_u;
  logic [31:0] a_mag, b_mag, div_s_den, div_u_den;
  logic [31:0] q_mag, r_mag, q_s, r_s, q_u, r_u;

  // Datapath: both products and both divides, computed from the operands of the start cycle.
  // Signed divide goes through magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow case.
  // A zero divisor is replaced by 1 only to keep the divider defined; that result is never written.
  always_comb begin
    prod_s    = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    prod_u    = {32'd0, A} * {32'd0, B};
    a_mag     = A[31] ? (32'd0 - A) : A;
    b_mag     = B[31] ? (32'd0 - B) : B;
    div_s_den = (B == 32'd0) ? 32'd1 : b_mag;
    div_u_den = (B == 32'd0) ? 32'd1 : B;
    q_mag     = a_mag / div_s_den;
    r_mag     = a_mag % div_s_den;
    q_s       = (A[31] ^ B[31]) ? (32'd0 - q_mag) : q_mag;
    r_s       = A[31] ? (32'd0 - r_mag) : r_mag;
    q_u       = A / div_u_den;
    r_u       = A % div_u_den;
  end

  // Next-state logic: accept ops in IDLE, count down in RUN, commit HI/LO on the final count.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    busy_nxt   = busy;
    res_hi_nxt = res_hi;
    res_lo_nxt = res_lo;
    res_wr_nxt = res_wr;
    hi_nxt     = HI;
    lo_nxt     = LO;
    case (state)
      IDLE: begin
        if (!kill) begin
          if (start && (HILO_Op >= OP_MULT) && (HILO_Op <= OP_DIVU)) begin
            state_nxt = RUN;
            busy_nxt  = 1'b1;
            case (HILO_Op)
              OP_MULT: begin
                {res_hi_nxt, res_lo_nxt} = prod_s;
                res_wr_nxt = 1'b1;
                cnt_nxt    = 16'(MULT_CYCLES);
              end
              OP_MULTU: begin
                {res_hi_nxt, res_lo_nxt} = prod_u;
                res_wr_nxt = 1'b1;
                cnt_nxt    = 16'(MULT_CYCLES);
              end
              OP_DIV: begin
                res_hi_nxt = r_s;
                res_lo_nxt = q_s;
                res_wr_nxt = (B != 32'd0);
                cnt_nxt    = 16'(DIV_CYCLES);
              end
              default: begin
                res_hi_nxt = r_u;
                res_lo_nxt = q_u;
                res_wr_nxt = (B != 32'd0);
                cnt_nxt    = 16'(DIV_CYCLES);
              end
            endcase
          end else if (HILO_Op == OP_MTHI) begin
            hi_nxt = A;
          end else if (HILO_Op == OP_MTLO) begin
            lo_nxt = A;
          end
        end
      end
      default: begin
        if (kill) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          cnt_nxt   = 16'd0;
        end else begin
          cnt_nxt = cnt - 16'd1;
          if (cnt == 16'd1) begin
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            if (res_wr) begin
              hi_nxt = res_hi;
              lo_nxt = res_lo;
            end
          end
        end
      end
    endcase
  end

  // State, counter, latched result and the architectural HI/LO registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= 16'd0;
      busy   <= 1'b0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      res_wr <= 1'b0;
      HI     <= 32'd0;
      LO     <= 32'd0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      busy   <= busy_nxt;
      res_hi <= res_hi_nxt;
      res_lo <= res_lo_nxt;
      res_wr <= res_wr_nxt;
      HI     <= hi_nxt;
      LO     <= lo_nxt;
    end
  end

  // mfhi/mflo read port, straight from the registers with no bypass.
  always_comb begin
    HILO_Out = 32'd0;
    if (HILO_Op == OP_MFHI)      HILO_Out = HI;
    else if (HILO_Op == OP_MFLO) HILO_Out = LO;
  end

endmodule
